// File: rtl/pippo_div_ctrl.sv
// pippo_div_ctrl: sequences RISC-V DIV/DIVU/REM/REMU ops through the
// pipelined 64/32 divider. Trivial cases (divide by zero, signed overflow,
// unsigned divisor >= 2^31) are answered in one cycle without the divider.
//
// Handshake: start is accepted only in IDLE with flush low. busy is high
// while the divider is in use (RUN/WAIT). done pulses for exactly one cycle
// when result becomes valid; result then holds until the next accepted op.
module pippo_div_ctrl #(
  parameter int DIV_LAT = 35,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_ena,
  output logic [63:0] div_z,
  output logic [31:0] div_d,
  input  logic [32:0] div_q,
  input  logic [32:0] div_s,
  input  logic        div_ovf,
  input  logic        div_div0
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

  state_t             state, state_n;
  logic               busy_n, done_n, ena_n;
  logic [31:0]        result_n;
  logic [63:0]        z_n;
  logic [31:0]        d_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [1:0]         op_q, op_n;

  // Classification of the incoming operation (op[0]=unsigned, op[1]=remainder)
  logic               is_signed, is_rem;
  logic               div_zero, sgn_ovf, big_div, bypass;
  logic               big_q;
  logic [31:0]        byp_q, byp_r;

  // Divider status flags and the quotient/remainder top bits carry no
  // information for 32-bit results.
  logic               unused;
  assign unused = ^{div_ovf, div_div0, div_q[32], div_s[32]};

  // Decide whether the op can be answered without the divider
  always_comb begin
    is_signed = ~op[0];
    is_rem    = op[1];
    div_zero  = (rs2 == 32'd0);
    sgn_ovf   = is_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    big_div   = !is_signed && rs2[31];
    bypass    = div_zero || sgn_ovf || big_div;
    big_q     = (rs1 >= rs2);
    byp_q     = 32'd0;
    byp_r     = 32'd0;
    if (div_zero) begin
      byp_q = 32'hFFFF_FFFF;
      byp_r = rs1;
    end else if (sgn_ovf) begin
      byp_q = 32'h8000_0000;
      byp_r = 32'd0;
    end else if (big_div) begin
      byp_q = {31'd0, big_q};
      byp_r = big_q ? (rs1 - rs2) : rs1;
    end
  end

  // Register state and all outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 32'd0;
      div_ena <= 1'b0;
      div_z   <= 64'd0;
      div_d   <= 32'd0;
      cnt     <= '0;
      op_q    <= 2'b00;
    end else begin
      state   <= state_n;
      busy    <= busy_n;
      done    <= done_n;
      result  <= result_n;
      div_ena <= ena_n;
      div_z   <= z_n;
      div_d   <= d_n;
      cnt     <= cnt_n;
      op_q    <= op_n;
    end
  end

  // Next-state and next-output logic; operands stay frozen while running so
  // the divider output can only reflect the current op.
  always_comb begin
    state_n  = state;
    busy_n   = busy;
    done_n   = 1'b0;
    result_n = result;
    ena_n    = div_ena;
    z_n      = div_z;
    d_n      = div_d;
    cnt_n    = cnt;
    op_n     = op_q;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          op_n = op;
          if (bypass) begin
            result_n = is_rem ? byp_r : byp_q;
            done_n   = 1'b1;
            state_n  = DONE;
          end else begin
            z_n     = is_signed ? {{32{rs1[31]}}, rs1} : {32'd0, rs1};
            d_n     = rs2;
            cnt_n   = '0;
            ena_n   = 1'b1;
            busy_n  = 1'b1;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (flush) begin
          ena_n   = 1'b0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_LAT - 1)) begin
            ena_n   = 1'b0;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          result_n = op_q[1] ? div_s[31:0] : div_q[31:0];
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        ena_n   = 1'b0;
      end
    endcase
  end

endmodule
